// File: rtl/logic_pkg.sv
// Shared definitions for the registered bitwise logic unit: op encoding and op type.
package logic_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_AND  = 2'd0;
    localparam op_t OP_OR   = 2'd1;
    localparam op_t OP_XOR  = 2'd2;
    localparam op_t OP_NAND = 2'd3;

endpackage : logic_pkg

// File: rtl/logic_op_comb.sv
// Purely combinational bitwise operator with zero detect; sits between the two pipe stages.
module logic_op_comb
    import logic_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  op_t              op,
    output logic [WIDTH-1:0] z,
    output logic             zero
);

    always_comb begin
        z = '0;
        unique case (op)
            OP_AND:  z = x & y;
            OP_OR:   z = x | y;
            OP_XOR:  z = x ^ y;
            OP_NAND: z = ~(x & y);
            default: z = '0;
        endcase
    end

    assign zero = (z == '0);

endmodule : logic_op_comb

// File: rtl/reg_logic_pipe.sv
// Two-stage valid/ready pipe: stage 1 registers operands, stage 2 registers op result and zero flag.
module reg_logic_pipe
    import logic_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_z,
    output logic             out_zero
);

    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    op_t              op_q, op_d;
    logic             v1_q, v1_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             zero_q, zero_d;
    logic             v2_q, v2_d;

    logic             adv1;
    logic             adv2;
    logic [WIDTH-1:0] comb_z;
    logic             comb_zero;

    // An empty stage always advances, so bubbles collapse under a downstream stall.
    assign adv2     = !v2_q || out_ready;
    assign adv1     = !v1_q || adv2;
    assign in_ready = adv1 && !reset;

    logic_op_comb #(
        .WIDTH (WIDTH)
    ) u_op (
        .x    (x_q),
        .y    (y_q),
        .op   (op_q),
        .z    (comb_z),
        .zero (comb_zero)
    );

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        op_d   = op_q;
        v1_d   = v1_q;
        z_d    = z_q;
        zero_d = zero_q;
        v2_d   = v2_q;
        if (adv1) begin
            x_d  = in_x;
            y_d  = in_y;
            op_d = op_t'(in_op);
            v1_d = in_valid && in_ready;
        end
        if (adv2) begin
            z_d    = comb_z;
            zero_d = comb_zero;
            v2_d   = v1_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x_q    <= '0;
            y_q    <= '0;
            op_q   <= OP_AND;
            v1_q   <= 1'b0;
            z_q    <= '0;
            zero_q <= 1'b0;
            v2_q   <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            op_q   <= op_d;
            v1_q   <= v1_d;
            z_q    <= z_d;
            zero_q <= zero_d;
            v2_q   <= v2_d;
        end
    end

    assign out_valid = v2_q;
    assign out_z     = z_q;
    assign out_zero  = zero_q;

endmodule : reg_logic_pipe

// File: tb/tb_reg_logic_pipe.sv
// Bench for reg_logic_pipe: 8-bit instance against a queue model, plus 1- and 64-bit corner instances.
module tb_reg_logic_pipe;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic       in_valid, in_ready, out_valid, out_ready, out_zero;
    logic [7:0] in_x, in_y, out_z;
    logic [1:0] in_op;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_zero;
    logic [0:0]  a_in_x, a_in_y, a_out_z;
    logic [1:0]  a_in_op;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_zero;
    logic [63:0] b_in_x, b_in_y, b_out_z;
    logic [1:0]  b_in_op;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];

    reg_logic_pipe #(.WIDTH(8)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_op(in_op), .out_valid(out_valid),
        .out_ready(out_ready), .out_z(out_z), .out_zero(out_zero)
    );

    reg_logic_pipe #(.WIDTH(1)) dut_w1 (
        .clock(clock), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_x(a_in_x), .in_y(a_in_y), .in_op(a_in_op), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_z(a_out_z), .out_zero(a_out_zero)
    );

    reg_logic_pipe #(.WIDTH(64)) dut_w64 (
        .clock(clock), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_x(b_in_x), .in_y(b_in_y), .in_op(b_in_op), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_z(b_out_z), .out_zero(b_out_zero)
    );

    // Reference result {zero, z} for the 8-bit instance.
    function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        logic [7:0] r;
        case (op)
            2'd0:    r = a & b;
            2'd1:    r = a | b;
            2'd2:    r = a ^ b;
            default: r = ~(a & b);
        endcase
        return {(r == 8'd0), r};
    endfunction

    // Transaction recorder: handshakes are stable between the falling and next rising edge.
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) obs_q.push_back({out_zero, out_z});
            if (in_valid && in_ready) exp_q.push_back(model8(in_x, in_y, in_op));
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input int n);
        for (int c = 0; c < 20 && obs_q.size() < n; c++) cyc();
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_x = 8'h12; in_y = 8'h34; in_op = 2'd1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: out_valid=%b in_ready=%b expected 0 0", i, out_valid, in_ready);
            end
        end
        reset = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 1", in_ready);
        end
        obs_q.delete();
        for (int i = 0; i < 4; i++) cyc();
        checks++;
        if (obs_q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_output: outputs=%0d out_valid=%b expected 0 0", obs_q.size(), out_valid);
        end
        $display("test_reset done");
    endtask

    task automatic test_op_sweep();
        logic [7:0] want [4];
        want[0] = 8'h30; want[1] = 8'hFC; want[2] = 8'hCC; want[3] = 8'hCF;
        out_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            in_valid = (t < 4);
            in_x = 8'hF0; in_y = 8'h3C; in_op = 2'(t);
            cyc();
            if (t == 0) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep_latency: out_valid=%b after 1 edge expected 0", out_valid);
                end
            end else if (t <= 4) begin
                checks++;
                if (out_valid !== 1'b1 || out_z !== want[t-1] || out_zero !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep_op%0d: valid=%b z=%h zero=%b expected 1 %h 0",
                             t-1, out_valid, out_z, out_zero, want[t-1]);
                end
            end
        end
        $display("test_op_sweep done");
    endtask

    task automatic test_zero_flag();
        int c;
        out_ready = 1'b1;
        in_valid = 1'b1; in_x = 8'hAA; in_y = 8'h55; in_op = 2'd0;
        cyc();
        in_valid = 1'b0;
        for (c = 0; c < 10 && out_valid !== 1'b1; c++) cyc();
        checks++;
        if (out_valid !== 1'b1 || out_z !== 8'h00 || out_zero !== 1'b1) begin
            errors++;
            $display("FAIL zero_flag: valid=%b z=%h zero=%b expected 1 00 1", out_valid, out_z, out_zero);
        end
        cyc();
        $display("test_zero_flag done");
    endtask

    task automatic test_backpressure();
        int idx;
        logic acc;
        logic [7:0] held;
        obs_q.delete(); exp_q.delete();
        idx = 0; out_ready = 1'b0; held = 8'h00;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1; in_x = 8'(idx); in_y = 8'hFF; in_op = 2'd2;
            #1 acc = in_ready;
            cyc();
            if (acc) idx++;
            if (c == 2) held = out_z;
        end
        checks++;
        if (idx != 2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept_count: accepted=%0d in_ready=%b expected 2 0", idx, in_ready);
        end
        checks++;
        if (out_valid !== 1'b1 || out_z !== held || out_z !== 8'hFF) begin
            errors++;
            $display("FAIL bp_stall_hold: valid=%b z=%h held=%h expected 1 ff", out_valid, out_z, held);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 40 && idx < 5; c++) begin
            in_x = 8'(idx);
            #1 acc = in_ready;
            cyc();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        drain(5);
        checks++;
        if (idx != 5 || obs_q.size() != 5) begin
            errors++;
            $display("FAIL bp_count: accepted=%0d outputs=%0d expected 5 5", idx, obs_q.size());
        end
        for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== {1'b0, 8'hFF - 8'(i)}) begin
                errors++;
                $display("FAIL bp_order%0d: got %h expected %h", i, obs_q[i], {1'b0, 8'hFF - 8'(i)});
            end
        end
        $display("test_backpressure done");
    endtask

    task automatic test_mid_reset();
        logic [8:0] want;
        obs_q.delete(); exp_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_x = 8'($urandom); in_y = 8'($urandom); in_op = 2'($urandom);
            cyc();
        end
        in_valid = 1'b0; reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_flush: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        in_valid = 1'b1; in_x = 8'h5A; in_y = 8'h0F; in_op = 2'd2;
        want = model8(8'h5A, 8'h0F, 2'd2);
        cyc();
        in_valid = 1'b0;
        for (int c = 0; c < 8; c++) cyc();
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== want) begin
            errors++;
            $display("FAIL midreset_single: outputs=%0d first=%h expected 1 %h",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 9'h0, want);
        end
        $display("test_mid_reset done");
    endtask

    task automatic test_random();
        int max_occ;
        max_occ = 0;
        obs_q.delete(); exp_q.delete();
        for (int c = 0; c < 400; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_x = 8'($urandom); in_y = 8'($urandom); in_op = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cyc();
            if (exp_q.size() - obs_q.size() > max_occ) max_occ = exp_q.size() - obs_q.size();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        drain(exp_q.size());
        checks++;
        if (max_occ > 2) begin
            errors++;
            $display("FAIL rand_occupancy: max=%0d expected <=2", max_occ);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_count: outputs=%0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_txn%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        $display("test_random done: %0d transactions", exp_q.size());
    endtask

    task automatic test_width_corners();
        // Per-op result bit when both operands are all-ones / all-zeros (AND, OR, XOR, NAND).
        logic [3:0] ones_bit;
        logic [3:0] zeros_bit;
        logic       bit_w;
        int         k;
        ones_bit  = 4'b0011;
        zeros_bit = 4'b1000;
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        for (int t = 0; t < 10; t++) begin
            a_in_valid = (t < 8); b_in_valid = (t < 8);
            a_in_op = 2'(t); b_in_op = 2'(t);
            a_in_x = (t < 4) ? 1'b1 : 1'b0;  a_in_y = a_in_x;
            b_in_x = (t < 4) ? '1 : '0;      b_in_y = b_in_x;
            cyc();
            if (t >= 1 && t <= 8) begin
                k = t - 1;
                bit_w = (k < 4) ? ones_bit[k % 4] : zeros_bit[k % 4];
                checks++;
                if (a_out_valid !== 1'b1 || a_out_z !== bit_w || a_out_zero !== !bit_w) begin
                    errors++;
                    $display("FAIL w1_txn%0d: valid=%b z=%b zero=%b expected 1 %b %b",
                             k, a_out_valid, a_out_z, a_out_zero, bit_w, !bit_w);
                end
                checks++;
                if (b_out_valid !== 1'b1 || b_out_z !== {64{bit_w}} || b_out_zero !== !bit_w) begin
                    errors++;
                    $display("FAIL w64_txn%0d: valid=%b z=%h zero=%b expected 1 %h %b",
                             k, b_out_valid, b_out_z, b_out_zero, {64{bit_w}}, !bit_w);
                end
            end
        end
        $display("test_width_corners done");
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_x = '0; in_y = '0; in_op = '0; out_ready = 1'b1;
        a_in_valid = 1'b0; a_in_x = '0; a_in_y = '0; a_in_op = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_x = '0; b_in_y = '0; b_in_op = '0; b_out_ready = 1'b1;
        test_reset();
        test_op_sweep();
        test_zero_flag();
        test_backpressure();
        test_mid_reset();
        test_random();
        test_width_corners();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_reg_logic_pipe

// File: doc/reg_logic_pipe.md
# reg_logic_pipe

Two-stage registered bitwise logic unit, the parametrised successor to the single-bit registered AND gate. It accepts operand pairs of configurable width on a valid/ready handshake and registers them. It then applies one of four selectable bitwise operations and registers the result with a zero flag. Full backpressure is supported, so the block drops into datapaths that stall, such as the execute stage of the CPU pipeline.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width in bits; legal range 1..64.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset, sampled on the rising edge of `clock`.
- `in_valid` in 1: operand pair and op present.
- `in_ready` out 1: block can accept this cycle.
- `in_x` in WIDTH: operand x.
- `in_y` in WIDTH: operand y.
- `in_op` in 2: 0=AND, 1=OR, 2=XOR, 3=NAND.
- `out_valid` out 1: result present.
- `out_ready` in 1: consumer accepts this cycle.
- `out_z` out WIDTH: result.
- `out_zero` out 1: result is all zeros.

## Operation
- Stage 1 registers: `x_r`, `y_r`, `op_r`, `v1`. Stage 2 registers: `out_z`, `out_zero`, `v2`; `out_valid` = `v2`.
- Transfers:
  - Input accept = `in_valid && in_ready`.
  - Output accept = `out_valid && out_ready`.
- Advance terms:
  - `adv2` = `!v2 || out_ready`.
  - `adv1` = `!v1 || adv2`.
  - `in_ready` = `adv1 && !reset`.
- Stage 1 update:
  - When `adv1` is high, stage 1 loads the inputs and `v1` <= input accept.
  - When `adv1` is low, stage 1 holds.
- Stage 2 update:
  - When `adv2` is high, stage 2 loads `op(x_r, y_r)` and `v2` <= `v1`.
  - When `adv2` is low, stage 2 holds.
- Bubbles collapse: an empty stage always accepts, even while the downstream stage is stalled.
- `out_zero` = (computed result == 0) and is registered together with `out_z`.
- NAND is `~(x & y)` over the full WIDTH; no bits above WIDTH exist.
- Data registers load whenever their stage advances, whether or not the data is valid. Consumers qualify all data with `out_valid` only.
- Reset values:
  - `v1`, `v2`, `out_valid` = 0.
  - `x_r`, `y_r`, `op_r`, `out_z` = 0.
  - `out_zero` = 0.
  - `in_ready` = 0 while `reset` is high.
- Reset mid-operation: all in-flight data is discarded with no output. `in_ready` returns to 1 in the first cycle after `reset` is released.

## Timing
- Latency: an operand accepted at edge k has its result visible, with `out_valid`=1, in the cycle after edge k+1 (2 edges), provided no stall occurs.
- Throughput: one result per cycle while `out_ready` is held high.
- Stall: while `out_valid && !out_ready`, `out_z`/`out_zero`/`out_valid` are held stable. Stall behaviour depends on stage 1:
  - If `v1`=1, `in_ready` drops in the same cycle (combinational path from `out_ready`).
  - If `v1`=0, one more input is accepted before `in_ready` drops.
- Maximum occupancy is 2 transactions. No transaction is ever dropped or duplicated.
- Simultaneous output accept and stage-1 valid: stage 2 is replaced in the same edge with no bubble.
- `in_op` is sampled only on input accept; changes at other times have no effect.
- Combinational paths:
  - `out_ready` -> `in_ready` exists.
  - No path from `in_valid` to any output.

## Structure
- The shared package `logic_pkg` holds:
  - the op encoding constants `OP_AND`=2'd0, `OP_OR`=2'd1, `OP_XOR`=2'd2, `OP_NAND`=2'd3;
  - the 2-bit op typedef.
- Sub-module `logic_op_comb` is purely combinational: inputs are WIDTH-parameterised x, y and op; outputs are z and zero. It sits between stage 1 and stage 2 and generalises the existing single-bit AND-assign gate.
- All sequential logic stays in `reg_logic_pipe`.

## Test plan
- Reset: hold `reset`=1 for 3 cycles with `in_valid`=1.
  - Required: `out_valid`=0 and `in_ready`=0 throughout.
  - Required: `in_ready`=1 in the first cycle after release.
  - Required: no output appears.
- Op sweep: WIDTH=8, x=8'hF0, y=8'h3C, ops 0..3 streamed back-to-back with `out_ready`=1.
  - Required: outputs 8'h30, 8'hFC, 8'hCC, 8'hCF appear on consecutive cycles, starting 2 edges after the first accept.
  - Required: `out_zero`=0 on all four.
- Zero flag: AND of x=8'hAA, y=8'h55.
  - Required: `out_z`=8'h00 and `out_zero`=1.
- Backpressure: stream 5 XOR transactions (x=i, y=8'hFF) while `out_ready`=0 for cycles 2..6.
  - Required: exactly 2 transactions are accepted, then `in_ready`=0.
  - Required: after `out_ready` rises, all 5 results 8'hFF..8'hFB emerge in order with no loss or duplication.
- Mid-operation reset: assert `reset` for 1 cycle while 2 transactions are in flight.
  - Required: `out_valid`=0 on the next cycle.
  - Required: the next accepted transaction produces the only subsequent output.
- Width corners: repeat the op sweep at WIDTH=1 and WIDTH=64, using all-ones and all-zeros operands.
  - Required: NAND of all-ones gives 0 with `out_zero`=1.
  - Required: NAND of all-zeros gives all-ones.
